// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, funct codes,
// ALU op classes, ALU controls and controller state codes.
package mips_pkg;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [3:0] S_FETCH   = 4'd0;
   localparam logic [3:0] S_DECODE  = 4'd1;
   localparam logic [3:0] S_MEMADR  = 4'd2;
   localparam logic [3:0] S_MEMRD   = 4'd3;
   localparam logic [3:0] S_MEMWB   = 4'd4;
   localparam logic [3:0] S_MEMWR   = 4'd5;
   localparam logic [3:0] S_EXECUTE = 4'd6;
   localparam logic [3:0] S_ALUWB   = 4'd7;
   localparam logic [3:0] S_BRANCH  = 4'd8;
   localparam logic [3:0] S_ADDIEX  = 4'd9;
   localparam logic [3:0] S_ADDIWB  = 4'd10;
   localparam logic [3:0] S_JUMP    = 4'd11;
endpackage

// File: rtl/aludec.sv
// ALU decoder: maps the ALU op class and the funct field to an ALU control code.
module aludec
   import mips_pkg::*;
(
   input  logic [5:0] funct,
   input  logic [1:0] aluop,
   output logic [2:0] alucontrol
);
   always_comb begin
      alucontrol = ALU_ADD;
      casez (aluop)
         2'b00: alucontrol = ALU_ADD;
         2'b01: alucontrol = ALU_SUB;
         default: begin
            case (funct)
               F_ADD:   alucontrol = ALU_ADD;
               F_SUB:   alucontrol = ALU_SUB;
               F_AND:   alucontrol = ALU_AND;
               F_OR:    alucontrol = ALU_OR;
               F_SLT:   alucontrol = ALU_SLT;
               default: alucontrol = ALU_AND;
            endcase
         end
      endcase
   end
endmodule

// File: rtl/mc_fsm.sv
// Multicycle control FSM: state register, next-state logic and per-state output decode.
//
// state   | meaning
// FETCH   | read instruction at PC, PC += 4 once memory is ready
// DECODE  | read registers, precompute branch target, dispatch on opcode
// MEMADR  | compute lw/sw effective address
// MEMRD   | read data memory, wait for ready
// MEMWB   | write loaded data to rt
// MEMWR   | write data memory, wait for ready
// EXECUTE | R-type ALU operation
// ALUWB   | write ALU result to rd
// BRANCH  | compare for beq, load PC with branch target on zero
// ADDIEX  | rs + SignImm
// ADDIWB  | write addi result to rt
// JUMP    | load PC with jump target
module mc_fsm
   import mips_pkg::*;
#(
   parameter int STATE_W = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic       mem_ready,
   output logic       iord,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [1:0] aluop,
   output logic       regdst,
   output logic       memtoreg,
   output logic       irwrite,
   output logic       memwrite,
   output logic       regwrite,
   output logic       pcwrite,
   output logic       branch,
   output logic       instr_done,
   output logic       illegal_op
);
   logic [STATE_W-1:0] state_q, state_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      iord       = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      pcsrc      = 2'b00;
      aluop      = ALUOP_ADD;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      irwrite    = 1'b0;
      memwrite   = 1'b0;
      regwrite   = 1'b0;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      instr_done = 1'b0;
      illegal_op = 1'b0;
      case (state_q)
         S_FETCH: begin
            alusrcb = 2'b01;
            irwrite = mem_ready;
            pcwrite = mem_ready;
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            alusrcb = 2'b11;
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXECUTE;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               default: begin
                  illegal_op = 1'b1;
                  state_d    = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            iord = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            memtoreg   = 1'b1;
            regwrite   = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWR: begin
            // Strobe held through stall cycles; memory samples it until ready.
            iord       = 1'b1;
            memwrite   = 1'b1;
            instr_done = mem_ready;
            if (mem_ready) state_d = S_FETCH;
         end
         S_EXECUTE: begin
            alusrca = 1'b1;
            aluop   = ALUOP_FUNCT;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            regdst     = 1'b1;
            regwrite   = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_BRANCH: begin
            alusrca    = 1'b1;
            aluop      = ALUOP_SUB;
            pcsrc      = 2'b01;
            branch     = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            state_d = S_ADDIWB;
         end
         S_ADDIWB: begin
            regwrite   = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_JUMP: begin
            pcsrc      = 2'b10;
            pcwrite    = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end
endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS controller top: FSM plus ALU decoder, PC enable and reset gating
// of every strobe so nothing writes while reset is held.
module multicycle_controller
   import mips_pkg::*;
#(
   parameter int STATE_W = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       iord,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [2:0] alucontrol,
   output logic       regdst,
   output logic       memtoreg,
   output logic       irwrite,
   output logic       memwrite,
   output logic       regwrite,
   output logic       pcen,
   output logic       instr_done,
   output logic       illegal_op
);
   logic [1:0] aluop;
   logic       irwrite_f, memwrite_f, regwrite_f, pcwrite_f, branch_f;
   logic       done_f, illegal_f;

   mc_fsm #(.STATE_W(STATE_W)) u_fsm (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .mem_ready  (mem_ready),
      .iord       (iord),
      .alusrca    (alusrca),
      .alusrcb    (alusrcb),
      .pcsrc      (pcsrc),
      .aluop      (aluop),
      .regdst     (regdst),
      .memtoreg   (memtoreg),
      .irwrite    (irwrite_f),
      .memwrite   (memwrite_f),
      .regwrite   (regwrite_f),
      .pcwrite    (pcwrite_f),
      .branch     (branch_f),
      .instr_done (done_f),
      .illegal_op (illegal_f)
   );

   aludec u_aludec (
      .funct      (funct),
      .aluop      (aluop),
      .alucontrol (alucontrol)
   );

   // FETCH drives irwrite/pcwrite from mem_ready, so gate explicitly during reset.
   assign irwrite    = irwrite_f  & ~reset;
   assign memwrite   = memwrite_f & ~reset;
   assign regwrite   = regwrite_f & ~reset;
   assign instr_done = done_f     & ~reset;
   assign illegal_op = illegal_f  & ~reset;
   assign pcen       = (pcwrite_f | (branch_f & zero)) & ~reset;
endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: builds the expected per-cycle output trace of
// each instruction from its op, funct, zero and memory wait counts, then replays it.
module tb_multicycle_controller;
   typedef struct packed {
      logic       iord;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      logic [2:0] alucontrol;
      logic       regdst;
      logic       memtoreg;
      logic       irwrite;
      logic       memwrite;
      logic       regwrite;
      logic       pcen;
      logic       instr_done;
      logic       illegal_op;
   } out_t;

   typedef struct packed {
      logic       rst;
      logic       mr;
      logic       z;
      logic [5:0] op;
      logic [5:0] funct;
      out_t       o;
   } ent_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] op = 6'd0;
   logic [5:0] funct = 6'd0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       iord, alusrca, regdst, memtoreg, irwrite, memwrite, regwrite;
   logic       pcen, instr_done, illegal_op;
   logic [1:0] alusrcb, pcsrc;
   logic [2:0] alucontrol;

   ent_t trace[$];
   ent_t exp_q[$];
   ent_t ce;
   out_t got;
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;

   always #5 clk = ~clk;

   multicycle_controller #(.STATE_W(4)) dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .iord(iord), .alusrca(alusrca), .alusrcb(alusrcb),
      .pcsrc(pcsrc), .alucontrol(alucontrol), .regdst(regdst), .memtoreg(memtoreg),
      .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite), .pcen(pcen),
      .instr_done(instr_done), .illegal_op(illegal_op)
   );

   // Compare process: one check per replayed cycle, away from the rising edge.
   always @(negedge clk) begin
      cyc++;
      if (exp_q.size() > 0) begin
         ce  = exp_q.pop_front();
         got = '{iord, alusrca, alusrcb, pcsrc, alucontrol, regdst, memtoreg,
                 irwrite, memwrite, regwrite, pcen, instr_done, illegal_op};
         tests++;
         if (got !== ce.o) begin
            fails++;
            $display("FAIL outputs cycle=%0d op=%b rst=%b mr=%b z=%b got=%b want=%b",
                     cyc, ce.op, ce.rst, ce.mr, ce.z, got, ce.o);
         end
      end
   end

   function automatic logic rb();
      return logic'($urandom_range(0, 1));
   endfunction

   function automatic out_t idle();
      out_t o = '0;
      o.alucontrol = 3'b010;
      return o;
   endfunction

   function automatic logic [2:0] alu_of(input logic [5:0] f);
      case (f)
         6'b100000: return 3'b010;
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b000;
      endcase
   endfunction

   function automatic void push(input logic rst, input logic mr, input logic z,
                                input logic [5:0] o_p, input logic [5:0] f, input out_t o);
      ent_t e;
      e.rst = rst; e.mr = mr; e.z = z; e.op = o_p; e.funct = f; e.o = o;
      trace.push_back(e);
   endfunction

   function automatic void add_reset(input logic [5:0] o_p, input logic [5:0] f);
      out_t o = idle();
      o.alusrcb = 2'b01;
      push(1'b1, rb(), rb(), o_p, f, o);
   endfunction

   // Expected trace of one instruction; bz < 0 means random zero in the branch cycle.
   function automatic void build(input logic [5:0] o_p, input logic [5:0] f,
                                 input int fw, input int mw, input int bz);
      out_t o;
      logic z;
      for (int i = 0; i < fw; i++) begin
         o = idle(); o.alusrcb = 2'b01;
         push(1'b0, 1'b0, rb(), o_p, f, o);
      end
      o = idle(); o.alusrcb = 2'b01; o.irwrite = 1'b1; o.pcen = 1'b1;
      push(1'b0, 1'b1, rb(), o_p, f, o);
      o = idle(); o.alusrcb = 2'b11;
      if (!(o_p inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010})) begin
         o.illegal_op = 1'b1;
         push(1'b0, rb(), rb(), o_p, f, o);
         return;
      end
      push(1'b0, rb(), rb(), o_p, f, o);
      case (o_p)
         6'b100011, 6'b101011: begin
            o = idle(); o.alusrca = 1'b1; o.alusrcb = 2'b10;
            push(1'b0, rb(), rb(), o_p, f, o);
            o = idle(); o.iord = 1'b1; o.memwrite = (o_p == 6'b101011);
            for (int i = 0; i < mw; i++) push(1'b0, 1'b0, rb(), o_p, f, o);
            o.instr_done = (o_p == 6'b101011);
            push(1'b0, 1'b1, rb(), o_p, f, o);
            if (o_p == 6'b100011) begin
               o = idle(); o.memtoreg = 1'b1; o.regwrite = 1'b1; o.instr_done = 1'b1;
               push(1'b0, rb(), rb(), o_p, f, o);
            end
         end
         6'b000000: begin
            o = idle(); o.alusrca = 1'b1; o.alucontrol = alu_of(f);
            push(1'b0, rb(), rb(), o_p, f, o);
            o = idle(); o.regdst = 1'b1; o.regwrite = 1'b1; o.instr_done = 1'b1;
            push(1'b0, rb(), rb(), o_p, f, o);
         end
         6'b000100: begin
            z = (bz < 0) ? rb() : logic'(bz);
            o = idle(); o.alusrca = 1'b1; o.alucontrol = 3'b110; o.pcsrc = 2'b01;
            o.pcen = z; o.instr_done = 1'b1;
            push(1'b0, rb(), z, o_p, f, o);
         end
         6'b001000: begin
            o = idle(); o.alusrca = 1'b1; o.alusrcb = 2'b10;
            push(1'b0, rb(), rb(), o_p, f, o);
            o = idle(); o.regwrite = 1'b1; o.instr_done = 1'b1;
            push(1'b0, rb(), rb(), o_p, f, o);
         end
         default: begin
            o = idle(); o.pcsrc = 2'b10; o.pcen = 1'b1; o.instr_done = 1'b1;
            push(1'b0, rb(), rb(), o_p, f, o);
         end
      endcase
   endfunction

   task automatic chk(input string name, input int g, input int w);
      tests++;
      if (g != w) begin
         fails++;
         $display("FAIL %s got=%0d want=%0d", name, g, w);
      end
   endtask

   task automatic play();
      ent_t e;
      while (trace.size() > 0) begin
         e = trace.pop_front();
         @(posedge clk);
         #1;
         reset = e.rst; mem_ready = e.mr; zero = e.z; op = e.op; funct = e.funct;
         exp_q.push_back(e);
      end
   endtask

   initial begin
      int base, n, keep;
      logic [5:0] ops[7];
      logic [5:0] fns[6];
      logic [5:0] o_p, f;
      ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b111111};
      fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};

      add_reset(6'b000000, 6'b100000);
      add_reset(6'b000000, 6'b100000);
      play();

      // Reset while in EXECUTE: no ALUWB follows.
      base = trace.size();
      build(6'b000000, 6'b100000, 0, 0, -1);
      while (trace.size() > base + 2) void'(trace.pop_back());
      add_reset(6'b000000, 6'b100000);
      build(6'b000000, 6'b100000, 0, 0, -1);
      play();

      base = trace.size();
      build(6'b100011, 6'b000000, 0, 0, -1);
      chk("lw_len", trace.size() - base, 5);
      chk("lw_wb", {trace[base+4].o.regwrite, trace[base+4].o.memtoreg, trace[base+4].o.instr_done}, 3'b111);
      play();

      base = trace.size();
      build(6'b101011, 6'b000000, 0, 2, -1);
      n = 0;
      foreach (trace[i]) if (i >= base && trace[i].o.memwrite) n++;
      chk("sw_len", trace.size() - base, 6);
      chk("sw_memwrite_cycles", n, 3);
      chk("sw_done_last", trace[base+5].o.instr_done, 1);
      play();

      base = trace.size();
      build(6'b000000, 6'b101010, 0, 0, -1);
      chk("slt_len", trace.size() - base, 4);
      chk("slt_alucontrol", trace[base+2].o.alucontrol, 3'b111);
      play();

      base = trace.size();
      build(6'b000100, 6'b000000, 0, 0, 1);
      chk("beq_len", trace.size() - base, 3);
      chk("beq_taken_pcen", trace[base+2].o.pcen, 1);
      build(6'b000100, 6'b000000, 0, 0, 0);
      chk("beq_not_taken_pcen", trace[base+5].o.pcen, 0);
      play();

      base = trace.size();
      build(6'b111111, 6'b000000, 1, 0, -1);
      chk("illegal_len", trace.size() - base, 3);
      chk("illegal_pulse", trace[base+2].o.illegal_op, 1);
      build(6'b000010, 6'b000000, 0, 0, -1);
      chk("j_len", trace.size() - base, 6);
      play();

      for (int k = 0; k < 300; k++) begin
         o_p = ops[$urandom_range(0, 6)];
         if ($urandom_range(0, 9) == 0) o_p = 6'($urandom);
         f = fns[$urandom_range(0, 5)];
         if ($urandom_range(0, 4) == 0) f = 6'($urandom);
         base = trace.size();
         build(o_p, f, $urandom_range(0, 2), $urandom_range(0, 2), -1);
         if ($urandom_range(0, 9) == 0) begin
            keep = $urandom_range(0, trace.size() - base - 1);
            while (trace.size() > base + keep) void'(trace.pop_back());
            add_reset(o_p, f);
            if (rb()) add_reset(o_p, f);
         end
         play();
      end

      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
